// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract controller.
// The requester drives the master side; serial_add_ctrl sits on the slave side.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             inp_start;
   logic             inp_sub;
   logic [WIDTH-1:0] inp_a;
   logic [WIDTH-1:0] inp_b;
   logic             inp_cin;
   logic             out_busy;
   logic             out_done;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_overflow;

   modport master (
      output inp_start, inp_sub, inp_a, inp_b, inp_cin,
      input  out_busy, out_done, out_result, out_carry, out_overflow
   );

   modport slave (
      input  inp_start, inp_sub, inp_a, inp_b, inp_cin,
      output out_busy, out_done, out_result, out_carry, out_overflow
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared 1-bit full-adder cell walks an
// operand pair LSB first, one bit per clock, with a start/busy/done handshake.
module serial_add_ctrl #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   serial_add_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] r_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry_ff;

   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH-1:0] r_next;

   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             overflow_q;

   logic             accepting;

   // The single full-adder cell shared by every bit position.
   always_comb begin
      fa_sum   = a_sh[0] ^ b_sh[0] ^ carry_ff;
      fa_carry = (a_sh[0] & b_sh[0]) | (carry_ff & (a_sh[0] ^ b_sh[0]));
   end

   // r_sh keeps only the upper WIDTH-1 partial bits; the lowest bit of the
   // finished word falls out of it on the MSB step.
   assign r_next    = {fa_sum, r_sh};
   assign accepting = (state == IDLE) || (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         r_sh       <= '0;
         cnt        <= '0;
         carry_ff   <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accepting && bus.inp_start) begin
                  a_sh     <= bus.inp_a;
                  b_sh     <= bus.inp_sub ? ~bus.inp_b : bus.inp_b;
                  carry_ff <= bus.inp_sub ? 1'b1 : bus.inp_cin;
                  cnt      <= '0;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
               r_sh     <= r_next[WIDTH-1:1];
               carry_ff <= fa_carry;
               cnt      <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
                  // carry_ff here is the carry into the MSB, fa_carry the carry out.
                  result_q   <= r_next;
                  carry_q    <= fa_carry;
                  overflow_q <= carry_ff ^ fa_carry;
                  done_q     <= 1'b1;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_busy     = (state == RUN);
   assign bus.out_done     = done_q;
   assign bus.out_result   = result_q;
   assign bus.out_carry    = carry_q;
   assign bus.out_overflow = overflow_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl at WIDTH=8 with a result scoreboard.
module tb_serial_add_ctrl;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         carry;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   serial_add_ctrl_if #(.WIDTH(W)) bus();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_acc  = 0;
   int   n_done = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
      exp_t         m;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb      = sub ? ~b : b;
      full    = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
      m.res   = full[W-1:0];
      m.carry = full[W];
      m.ovf   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return m;
   endfunction

   // Advance to the next falling edge and score any completed operation.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (bus.out_done === 1'b1) begin
         n_done++;
         chk("sb_nonempty", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", bus.out_result, e.res);
            chk("carry", bus.out_carry, e.carry);
            chk("overflow", bus.out_overflow, e.ovf);
         end
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input exp_t e);
      bus.inp_a     = a;
      bus.inp_b     = b;
      bus.inp_sub   = sub;
      bus.inp_cin   = cin;
      bus.inp_start = 1'b1;
      sb.push_back(e);
      n_acc++;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input exp_t e);
      drive(a, b, sub, cin, e);
      for (int k = 1; k <= W; k++) begin
         step();
         if (k == 1) bus.inp_start = 1'b0;
         chk("busy_run", bus.out_busy, 1);
         chk("done_early", bus.out_done, 0);
      end
      step();
      chk("done_pulse", bus.out_done, 1);
      chk("busy_done", bus.out_busy, 0);
      step();
      chk("done_drop", bus.out_done, 0);
   endtask

   initial begin
      exp_t e;
      int   got;
      int   lat;
      int   gap;
      logic [W-1:0] ra, rb;
      logic rs, rc;

      rst = 1'b1;
      bus.inp_start = 1'b0;
      bus.inp_sub   = 1'b0;
      bus.inp_cin   = 1'b0;
      bus.inp_a     = '0;
      bus.inp_b     = '0;
      step();
      step();
      chk("rst_busy", bus.out_busy, 0);
      chk("rst_done", bus.out_done, 0);
      chk("rst_result", bus.out_result, 0);
      chk("rst_carry", bus.out_carry, 0);
      chk("rst_ovf", bus.out_overflow, 0);
      rst = 1'b0;
      step();

      // Directed arithmetic cases with hand-computed results.
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, '{res: 8'h80, carry: 1'b0, ovf: 1'b1});
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, '{res: 8'h00, carry: 1'b1, ovf: 1'b0});
      run_op(8'h10, 8'h20, 1'b0, 1'b1, '{res: 8'h31, carry: 1'b0, ovf: 1'b0});
      run_op(8'h05, 8'h07, 1'b1, 1'b0, '{res: 8'hFE, carry: 1'b0, ovf: 1'b0});
      run_op(8'h80, 8'h01, 1'b1, 1'b1, '{res: 8'h7F, carry: 1'b1, ovf: 1'b1});

      // Start/operand noise during RUN, then back-to-back start in DONE.
      drive(8'h12, 8'h34, 1'b0, 1'b0, '{res: 8'h46, carry: 1'b0, ovf: 1'b0});
      for (int k = 1; k <= W; k++) begin
         step();
         bus.inp_start = 1'b0;
         if (k == 2 || k == 5) begin
            bus.inp_start = 1'b1;
            bus.inp_a     = 8'hFF;
            bus.inp_b     = 8'hFF;
            bus.inp_sub   = 1'b1;
         end
         chk("hold_result", bus.out_result, 8'h7F);
         chk("hold_carry", bus.out_carry, 1);
         chk("hold_ovf", bus.out_overflow, 1);
      end
      step();
      chk("b2b_first_done", bus.out_done, 1);
      drive(8'h55, 8'h0A, 1'b1, 1'b0, '{res: 8'h4B, carry: 1'b1, ovf: 1'b0});
      for (int k = 1; k <= W + 1; k++) begin
         step();
         if (k == 1) bus.inp_start = 1'b0;
         if (k < W + 1) begin
            chk("b2b_no_done", bus.out_done, 0);
            chk("b2b_hold", bus.out_result, 8'h46);
         end else begin
            chk("b2b_second_done", bus.out_done, 1);
         end
      end
      step();

      // Reset in the middle of a run abandons the operation.
      drive(8'h33, 8'h44, 1'b0, 1'b0, '{res: 8'h77, carry: 1'b0, ovf: 1'b0});
      step();
      bus.inp_start = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_acc = n_acc - sb.size();
      sb.delete();
      chk("mid_rst_busy", bus.out_busy, 0);
      chk("mid_rst_done", bus.out_done, 0);
      chk("mid_rst_result", bus.out_result, 0);
      chk("mid_rst_carry", bus.out_carry, 0);
      chk("mid_rst_ovf", bus.out_overflow, 0);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("post_rst_quiet", bus.out_done, 0);
      end
      run_op(8'hC8, 8'h64, 1'b0, 1'b0, '{res: 8'h2C, carry: 1'b1, ovf: 1'b0});

      // Random operations with random idle gaps (gap 0 = back-to-back).
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         drive(ra, rb, rs, rc, model(ra, rb, rs, rc));
         got = 0;
         lat = 0;
         for (int k = 1; k <= 20 && got == 0; k++) begin
            step();
            if (k == 1) bus.inp_start = 1'b0;
            if (bus.out_done === 1'b1) begin
               got = 1;
               lat = k;
            end
         end
         chk("rand_done_seen", got, 1);
         chk("rand_latency", lat, W + 1);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) step();
      end
      repeat (W + 3) step();
      chk("done_count", n_done, n_acc);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
